// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage.
//
// Owns the fetch PC, issues single outstanding word reads to instruction
// memory, buffers returned {pc, instruction} pairs in a QDEPTH-entry circular
// prefetch queue and presents the queue head to decode via valid/ready.
// A branch/flush from execute empties the queue and redirects fetch; a
// request already in flight when the branch arrives is waited out and its
// data dropped.
//
// Parameters:
//   RESET_PC  fetch address after reset (bits [1:0] ignored)
//   QDEPTH    prefetch queue depth, power of two, >= 2
// Ports:
//   clk1, rst_n                  clock, asynchronous active-low reset
//   mem_req, mem_address         registered read request / word address
//   mem_ready, mem_read          memory return strobe and data
//   branch_valid, branch_target  one-cycle redirect from execute
//   d_valid, d_ready             decode handshake
//   d_instruction, d_pc          queue head word and its address
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk1,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_address,
  input  logic        mem_ready,
  input  logic [31:0] mem_read,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [31:0] d_instruction,
  output logic [31:0] d_pc
);

  localparam int unsigned   PW       = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned   CW       = $clog2(QDEPTH + 1);
  localparam logic [31:0]   START_PC = RESET_PC & ~32'h3;
  localparam logic [CW-1:0] FULL     = CW'(QDEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DISCARD
  } state_e;

  state_e        state_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   mem_address_q;
  logic          mem_req_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [31:0]   pc_buf_q  [QDEPTH];
  logic [31:0]   ins_buf_q [QDEPTH];

  logic [31:0] target;
  logic        push;
  logic        pop;
  logic        has_room;

  assign target = branch_target & ~32'h3;

  // A return is only accepted in REQ; a same-cycle branch drops it.
  assign push = (state_q == ST_REQ) && mem_ready && !branch_valid;
  assign pop  = (count_q != '0) && d_ready;

  always_comb begin
    count_d = count_q;
    if (branch_valid) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  assign has_room = (count_d < FULL);

  // Prefetch queue storage and pointers.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        pc_buf_q[i]  <= '0;
        ins_buf_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (branch_valid) begin
        // Flush collapses the write pointer onto the head so the head slot
        // (and thus d_pc/d_instruction) stays put until the next push.
        wr_ptr_q <= rd_ptr_q;
      end else begin
        if (push) begin
          pc_buf_q[wr_ptr_q]  <= mem_address_q;
          ins_buf_q[wr_ptr_q] <= mem_read;
          wr_ptr_q            <= wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  end

  // Request FSM with registered mem_req/mem_address.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      fetch_pc_q    <= START_PC;
      mem_address_q <= START_PC;
      mem_req_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (branch_valid) begin
            fetch_pc_q    <= target;
            mem_address_q <= target;
            mem_req_q     <= 1'b1;
            state_q       <= ST_REQ;
          end else if (has_room) begin
            mem_address_q <= fetch_pc_q;
            mem_req_q     <= 1'b1;
            state_q       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (branch_valid) begin
            fetch_pc_q <= target;
            if (mem_ready) begin
              mem_address_q <= target;
            end else begin
              state_q <= ST_DISCARD;
            end
          end else if (mem_ready) begin
            // Address tracks fetch_pc even when going idle, so a later
            // restart from IDLE re-issues the same value.
            fetch_pc_q    <= fetch_pc_q + 32'd4;
            mem_address_q <= fetch_pc_q + 32'd4;
            if (!has_room) begin
              mem_req_q <= 1'b0;
              state_q   <= ST_IDLE;
            end
          end
        end
        ST_DISCARD: begin
          if (branch_valid) begin
            fetch_pc_q <= target;
          end
          if (mem_ready) begin
            mem_address_q <= branch_valid ? target : fetch_pc_q;
            state_q       <= ST_REQ;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_address   = mem_address_q;
  assign d_valid       = (count_q != '0);
  assign d_pc          = pc_buf_q[rd_ptr_q];
  assign d_instruction = ins_buf_q[rd_ptr_q];

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the pipelined ARM core. Owns the fetch PC and issues word reads to instruction memory. Buffers returned words with their addresses in a small prefetch queue and hands them to the decode stage through a valid/ready handshake. Execute redirects it with a branch/flush request. It replaces the inline fetch logic in the top level and sits directly upstream of decode.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset. Bits [1:0] are ignored.
- `QDEPTH`, default 2: prefetch queue depth in entries. Must be a power of two, ≥2.
- `clk1`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mem_req`  out  1  read request to instruction memory (registered).
- `mem_address`  out  32  word-aligned read address (registered); bits [1:0] always 0.
- `mem_ready`  in  1  high in the cycle `mem_read` carries data for the pending request.
- `mem_read`  in  32  instruction word.
- `branch_valid`  in  1  one-cycle redirect/flush from execute.
- `branch_target`  in  32  new fetch address; bits [1:0] are forced to 0.
- `d_valid`  out  1  queue head holds a valid instruction.
- `d_ready`  in  1  decode accepts the head this cycle.
- `d_instruction`  out  32  head instruction word.
- `d_pc`  out  32  address of the head instruction.

## Operation
- Queue: circular buffer of QDEPTH {pc, instruction} entries.
  - `count` has QDEPTH+1 states.
  - `d_valid = (count != 0)`.
  - Pop when `d_valid & d_ready`.
  - Push on an accepted memory return.
  - A push and a pop in the same cycle leave `count` unchanged.
- `fetch_pc` register: address of the next word to request. It increments by 4 after each accepted return and wraps modulo 2^32 (0xFFFF_FFFC → 0).
- At most one request is outstanding. While `mem_req=1`, `mem_address` is held stable until `mem_ready`.
- FSM states:
  - IDLE: `mem_req=0`.
    - Go to REQ when `count_next < QDEPTH`; `mem_address ← fetch_pc`.
  - REQ: `mem_req=1`.
    - On `mem_ready` without branch: push {mem_address, mem_read}, `fetch_pc += 4`. Then go to REQ with the next address if `count_next < QDEPTH`, otherwise IDLE.
    - On `branch_valid` with `mem_ready`: drop the data, `fetch_pc ← target`, go to REQ at the target.
    - On `branch_valid` without `mem_ready`: go to DISCARD; `mem_address` is held.
  - DISCARD: `mem_req=1` and the old address is held.
    - On `mem_ready`: drop the data and go to REQ with `mem_address ← fetch_pc`.
    - A further `branch_valid` updates `fetch_pc` and the state stays DISCARD.
- Flush: `branch_valid` empties the queue (`count←0`) in the same edge. Any pop that cycle is irrelevant; the flush wins over the push/pop.
- A branch in IDLE goes to REQ with `mem_address ← target` at the next edge.

## Timing
- Reset values:
  - `mem_req=0`, `mem_address=RESET_PC&~3`, `d_valid=0`, `d_instruction=0`, `d_pc=0`
  - `fetch_pc=RESET_PC&~3`, state IDLE, `count=0`.
- Reset acts immediately and mid-operation. Any pending request is abandoned and memory must tolerate the `mem_req` drop.
- Edge 1 after `rst_n` rises: `mem_req=1`, `mem_address=RESET_PC`.
- Zero-wait memory (`mem_ready` in the same cycle as `mem_req`): the word is pushed at edge 2, so `d_valid=1` after edge 2. Fetch-to-decode latency is 1 cycle.
- Steady state with zero-wait memory and `d_ready=1`: one instruction per cycle with no bubbles.
- Redirect penalty with zero-wait memory: `branch_valid` at cycle t → `d_valid=0` in t+1; request at target in t+1; target word valid in t+2.
- `d_instruction`/`d_pc` change only on a pop, a push into an empty queue, or a flush.

## Test plan
- Reset, RESET_PC=0, zero-wait memory, mem[i]=0xE000_0000+i, `d_ready=1` → `d_valid` from edge 2; `d_pc` runs 0,4,8,12 on consecutive cycles with the matching words.
- `d_ready=0`, zero-wait → queue fills with pcs 0 and 4, `mem_req` drops to 0, `mem_address` stays 8; then `d_ready=1` → 0,4,8,… delivered with none lost or duplicated.
- Memory with 3 wait cycles → `mem_address` held constant while `mem_req=1`; `d_valid` pattern is one word per 4 cycles; pcs are sequential.
- Queue full (pcs 0,4), `branch_valid` with target 0x103 → `d_valid=0` next cycle, next request address 0x100, first delivered `d_pc=0x100`.
- Request to 0x8 pending with `mem_ready` delayed 2 cycles, `branch_valid` (target 0x40) in the first cycle → address 0x8 held until ready, its word is never delivered, next request is 0x40. A second branch to 0x80 during DISCARD → next request is 0x80.
- RESET_PC=0xFFFF_FFF8 → delivered pcs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0. `rst_n` pulsed low mid-request → all outputs return to reset values asynchronously and fetch restarts at RESET_PC.
